tone_gen: RTL and testbench

- Square-wave tone synthesiser directly downstream of the piano controller.
- Consumes a 6-bit note code {octave[2:0], note[2:0]} with a valid strobe.
- Produces a glitch-free square wave on the speaker pin, with 2-bit PWM volume gating.
- Note changes are applied only on waveform boundaries, so the speaker never sees runt pulses.

---
 rtl/piano_pkg.sv | 46 ++++
 rtl/tone_gen_if.sv | 19 +
 rtl/tone_period_lut.sv | 20 ++
 rtl/tone_gen.sv | 109 ++++++++++
 tb/tb_tone_gen.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/piano_pkg.sv
// Shared note/octave definitions for the piano controller and tone synthesiser.
// Holds the octave-1 half-period table in 100 MHz clock cycles.
package piano_pkg;

  typedef enum logic [2:0] {
    NOTE_SIL = 3'd0,
    NOTE_C   = 3'd1,
    NOTE_D   = 3'd2,
    NOTE_E   = 3'd3,
    NOTE_F   = 3'd4,
    NOTE_G   = 3'd5,
    NOTE_A   = 3'd6,
    NOTE_B   = 3'd7
  } note_e;

  localparam logic [2:0] OCT_MIN      = 3'd1;
  localparam logic [2:0] OCT_MAX      = 3'd7;
  localparam logic [5:0] CODE_SILENCE = 6'd0;

  localparam int unsigned BASE_C = 1528903;
  localparam int unsigned BASE_D = 1362097;
  localparam int unsigned BASE_E = 1213492;
  localparam int unsigned BASE_F = 1145383;
  localparam int unsigned BASE_G = 1020421;
  localparam int unsigned BASE_A = 909091;
  localparam int unsigned BASE_B = 809912;

  function automatic int unsigned base_half(input note_e n);
    case (n)
      NOTE_C:  return BASE_C;
      NOTE_D:  return BASE_D;
      NOTE_E:  return BASE_E;
      NOTE_F:  return BASE_F;
      NOTE_G:  return BASE_G;
      NOTE_A:  return BASE_A;
      NOTE_B:  return BASE_B;
      default: return 0;
    endcase
  endfunction

  // A code with no note or no octave asks for silence.
  function automatic logic is_silence(input logic [5:0] code);
    return (code[2:0] == NOTE_SIL) || (code[5:3] < OCT_MIN);
  endfunction

endpackage

// File: rtl/tone_gen_if.sv
// Note request / speaker bundle between the piano controller and tone_gen.
interface tone_gen_if;
  logic       note_valid;
  logic [5:0] note_code;
  logic [1:0] vol;
  logic       audio_out;
  logic       playing;
  logic [5:0] cur_code;

  modport master (
    output note_valid, note_code, vol,
    input  audio_out, playing, cur_code
  );

  modport slave (
    input  note_valid, note_code, vol,
    output audio_out, playing, cur_code
  );
endinterface

// File: rtl/tone_period_lut.sv
// Combinational note code to half-period: octave-1 table lookup then a right shift per octave.
module tone_period_lut
  import piano_pkg::*;
#(
  parameter int HALF_W = 21
) (
  input  logic [5:0]        code,
  output logic [HALF_W-1:0] half
);

  logic [31:0] base;
  logic [2:0]  shift;

  always_comb begin
    base  = base_half(note_e'(code[2:0]));
    shift = code[5:3] - OCT_MIN;
    half  = is_silence(code) ? '0 : HALF_W'(base >> shift);
  end

endmodule

// File: rtl/tone_gen.sv
// Square-wave tone generator: note changes land only on low-to-high boundaries,
// silence lands at the end of a high phase, and a 2-bit PWM gate sets the volume.
module tone_gen
  import piano_pkg::*;
#(
  parameter int HALF_W = 21,
  parameter int PWM_W  = 8
) (
  input logic       clk,
  input logic       rst_n,
  tone_gen_if.slave bus
);

  localparam logic [0:0] S_SILENT  = 1'b0;
  localparam logic [0:0] S_PLAYING = 1'b1;

  logic [0:0]        state;
  logic              sq;
  logic [HALF_W-1:0] cnt;
  logic [HALF_W-1:0] half;
  logic [5:0]        cur_code;
  logic [5:0]        pend_code;
  logic              pend_vld;
  logic [PWM_W-1:0]  pwm_cnt;
  logic              audio_q;
  logic              gate;

  logic boundary, pend_sil, pend_note, go_silent, take_note, req_ok;

  tone_period_lut #(.HALF_W(HALF_W)) u_lut (
    .code (cur_code),
    .half (half)
  );

  assign boundary  = (state == S_PLAYING) && (cnt == half - HALF_W'(1));
  assign pend_sil  = pend_vld && is_silence(pend_code);
  assign pend_note = pend_vld && !is_silence(pend_code);
  assign go_silent = (state == S_PLAYING) && pend_sil && (!sq || boundary);
  assign take_note = boundary && !sq && pend_note;
  // Re-requesting the note already sounding must not disturb a pending change.
  assign req_ok    = bus.note_valid && (state == S_PLAYING) && (bus.note_code != cur_code);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_SILENT;
      sq        <= 1'b0;
      cnt       <= '0;
      cur_code  <= CODE_SILENCE;
      pend_code <= CODE_SILENCE;
      pend_vld  <= 1'b0;
    end else begin
      if (state == S_SILENT) begin
        if (bus.note_valid && !is_silence(bus.note_code)) begin
          state    <= S_PLAYING;
          cur_code <= bus.note_code;
          cnt      <= '0;
          sq       <= 1'b1;
        end
      end else if (go_silent) begin
        state    <= S_SILENT;
        cur_code <= CODE_SILENCE;
        cnt      <= '0;
        sq       <= 1'b0;
      end else if (boundary) begin
        cnt <= '0;
        sq  <= ~sq;
        if (take_note) cur_code <= pend_code;
      end else begin
        cnt <= cnt + HALF_W'(1);
      end

      // A strobe on a boundary cycle is kept for the next boundary.
      if (go_silent) begin
        pend_vld <= 1'b0;
      end else if (req_ok) begin
        pend_code <= bus.note_code;
        pend_vld  <= 1'b1;
      end else if (take_note) begin
        pend_vld <= 1'b0;
      end
    end
  end

  always_comb begin
    gate = 1'b0; // NOTE: default first so no path leaves gate unassigned and infers a latch.
    unique case (bus.vol)
      2'd0:    gate = 1'b0;
      2'd1:    gate = (pwm_cnt[PWM_W-1 -: 2] == 2'b00);
      2'd2:    gate = ~pwm_cnt[PWM_W-1];
      default: gate = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      audio_q <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      audio_q <= sq & gate;
    end
  end

  assign bus.audio_out = audio_q;
  assign bus.playing   = (state == S_PLAYING);
  assign bus.cur_code  = cur_code;

endmodule

// File: tb/tb_tone_gen.sv
// Self-checking bench for tone_gen: start-up vector table plus hand-written
// phase-length, note-change, silence, volume and reset sequences.
module tb_tone_gen;

  localparam int HALF_B7 = 809912 >> 6;   // 12654
  localparam int HALF_A7 = 909091 >> 6;   // 14204

  typedef struct {
    logic [5:0] code;
    logic [1:0] vol;
    logic       exp_playing;
    logic [5:0] exp_cur;
    logic       exp_audio;
  } vec_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_errors;

  vec_t vecs [9];
  vec_t sb_q [$];
  int   phase_q [$];

  tone_gen_if bus ();

  tone_gen #(.HALF_W(21), .PWM_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic strobe(input logic [5:0] c);
    bus.note_valid = 1'b1;
    bus.note_code  = c;
    @(negedge clk);
    bus.note_valid = 1'b0;
    bus.note_code  = 6'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_level(input logic lvl, input int budget, input string name);
    int n;
    n = 0;
    while (bus.audio_out !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, bus.audio_out, lvl);
  endtask

  task automatic sb_phase(input string name, input int actual);
    int exp;
    exp = (phase_q.size() > 0) ? phase_q.pop_front() : 0;
    check(name, actual, exp);
  endtask

  task automatic quiet(input int n, input string name);
    int hi, pl;
    hi = 0;
    pl = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.audio_out !== 1'b0) hi++;
      if (bus.playing !== 1'b0) pl++;
    end
    check({name, " audio"}, hi, 0);
    check({name, " playing"}, pl, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t_rise, t_fall, t_rise2, t_fall2, cnt, pcnt;
    vec_t r;

    vecs[0] = '{6'o76, 2'd3, 1'b1, 6'o76, 1'b1};
    vecs[1] = '{6'o11, 2'd3, 1'b1, 6'o11, 1'b1};
    vecs[2] = '{6'o65, 2'd2, 1'b1, 6'o65, 1'b1};
    vecs[3] = '{6'o53, 2'd1, 1'b1, 6'o53, 1'b1};
    vecs[4] = '{6'o77, 2'd0, 1'b1, 6'o77, 1'b0};
    vecs[5] = '{6'o00, 2'd3, 1'b0, 6'o00, 1'b0};
    vecs[6] = '{6'o70, 2'd3, 1'b0, 6'o00, 1'b0};
    vecs[7] = '{6'o07, 2'd3, 1'b0, 6'o00, 1'b0};
    vecs[8] = '{6'o47, 2'd3, 1'b1, 6'o47, 1'b1};

    n_checks       = 0;
    n_errors       = 0;
    bus.note_valid = 1'b0;
    bus.note_code  = 6'd0;
    bus.vol        = 2'd3;
    rst_n          = 1'b1;
    #1 rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check("reset audio_out", bus.audio_out, 0);
    check("reset playing", bus.playing, 0);
    check("reset cur_code", bus.cur_code, 0);

    // Start-up table: each row from a fresh reset, one strobe, then two cycles of outputs.
    for (int i = 0; i < 9; i++) begin
      bus.vol = vecs[i].vol;
      do_reset();
      sb_q.push_back(vecs[i]);
      strobe(vecs[i].code);
      check($sformatf("vec%0d audio latency", i), bus.audio_out, 0);
      tick(1);
      r = sb_q.pop_front();
      check($sformatf("vec%0d playing", i), bus.playing, r.exp_playing);
      check($sformatf("vec%0d cur_code", i), bus.cur_code, r.exp_cur);
      check($sformatf("vec%0d audio", i), bus.audio_out, r.exp_audio);
    end

    // B7 tone; mid-high strobes E5, A7, then B7 again (dropped): A7 wins at the next rise.
    bus.vol = 2'd3;
    do_reset();
    phase_q.push_back(HALF_B7);
    phase_q.push_back(HALF_B7);
    strobe(6'o77);
    tick(1);
    t_rise = cyc;
    check("B7 first rise", bus.audio_out, 1);
    tick(100);
    strobe(6'o53);
    tick(10);
    phase_q.push_back(HALF_A7);
    strobe(6'o76);
    tick(10);
    strobe(6'o77);
    check("cur_code held in high", bus.cur_code, 6'o77);
    wait_level(1'b0, 20000, "B7 high end timeout");
    t_fall = cyc;
    sb_phase("B7 high phase", t_fall - t_rise);
    tick_until(t_fall + HALF_B7 - 2);
    check("cur_code held in low", bus.cur_code, 6'o77);
    tick(1);
    check("cur_code switches at rise", bus.cur_code, 6'o76);
    wait_level(1'b1, 10, "A7 rise timeout");
    t_rise2 = cyc;
    sb_phase("B7 low phase", t_rise2 - t_fall);

    // Volume gating inside the A7 high phase.
    bus.vol = 2'd1;
    cnt = 0;
    repeat (256) begin
      @(negedge clk);
      if (bus.audio_out === 1'b1) cnt++;
    end
    check("vol1 duty per 256", cnt, 64);
    bus.vol = 2'd2;
    cnt = 0;
    repeat (256) begin
      @(negedge clk);
      if (bus.audio_out === 1'b1) cnt++;
    end
    check("vol2 duty per 256", cnt, 128);
    bus.vol = 2'd0;
    cnt = 0;
    pcnt = 0;
    repeat (256) begin
      @(negedge clk);
      if (bus.audio_out === 1'b1) cnt++;
      if (bus.playing === 1'b1) pcnt++;
    end
    check("vol0 audio high count", cnt, 0);
    check("vol0 playing count", pcnt, 256);
    bus.vol = 2'd3;

    // Silence requested mid-high: the high phase completes, then everything stops.
    strobe(6'o00);
    tick_until(t_rise2 + HALF_A7 - 2);
    check("playing before silence edge", bus.playing, 1);
    check("audio before silence edge", bus.audio_out, 1);
    tick(1);
    check("playing at silence edge", bus.playing, 0);
    check("cur_code at silence edge", bus.cur_code, 0);
    wait_level(1'b0, 4, "A7 fall timeout");
    t_fall2 = cyc;
    sb_phase("A7 high phase", t_fall2 - t_rise2);
    quiet(300, "after silence (high)");

    // Silence requested during a low phase stops without waiting for the phase end.
    do_reset();
    phase_q.push_back(HALF_B7);
    strobe(6'o77);
    tick(1);
    t_rise = cyc;
    wait_level(1'b0, 20000, "B7 high end timeout (2)");
    sb_phase("B7 high phase (2)", cyc - t_rise);
    strobe(6'o00);
    tick(1);
    check("playing after low silence", bus.playing, 0);
    check("cur_code after low silence", bus.cur_code, 0);
    quiet(300, "after silence (low)");

    // Asynchronous reset mid-tone, then invalid and valid requests.
    do_reset();
    strobe(6'o77);
    tick(50);
    check("tone before reset", bus.audio_out, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset audio", bus.audio_out, 0);
    check("async reset playing", bus.playing, 0);
    check("async reset cur_code", bus.cur_code, 0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet(100, "after reset");
    strobe(6'o03);
    quiet(5, "octave 0 request");
    strobe(6'o71);
    tick(1);
    check("fresh strobe audio", bus.audio_out, 1);
    check("fresh strobe cur_code", bus.cur_code, 6'o71);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
